// File: rtl/rv_pkg.sv
// Shared core package: machine word width and architectural register count
// used as defaults throughout the core.
package rv_pkg;

  localparam int unsigned RV_XLEN = 32;
  localparam int unsigned RV_NREG = 32;

endpackage : rv_pkg

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: tracks registers awaiting writeback, raises issue
// stall on RAW/WAW hazards and flags writebacks to registers with no pending write.
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned NREG = RV_NREG,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic            iss_valid,
  input  logic            iss_wr,
  input  logic [AW-1:0]   iss_rd,
  output logic            stall,
  output logic [NREG-1:0] busy_vec,
  output logic            wb_err
);

  logic [NREG-1:0] busy_d;
  logic            rs1_hz;
  logic            rs2_hz;
  logic            waw_hz;
  logic            stall_c;
  logic            issue_set;

  // Hazard detection; a writeback landing this cycle resolves the hazard.
  always_comb begin
    rs1_hz    = 1'b0;
    rs2_hz    = 1'b0;
    waw_hz    = 1'b0;
    busy_d    = busy_vec;
    rs1_hz    = iss_valid && rs1_used && busy_vec[rs1_addr]
                && !(wr_en && (wr_addr == rs1_addr));
    rs2_hz    = iss_valid && rs2_used && busy_vec[rs2_addr]
                && !(wr_en && (wr_addr == rs2_addr));
    waw_hz    = iss_valid && iss_wr && (iss_rd != AW'(0)) && busy_vec[iss_rd]
                && !(wr_en && (wr_addr == iss_rd));
    stall_c   = rs1_hz || rs2_hz || waw_hz;
    issue_set = iss_valid && iss_wr && (iss_rd != AW'(0)) && !stall_c;
    // Clear first so a same-cycle set on the same register wins.
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (issue_set) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign stall = stall_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_vec <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy_vec <= busy_d;
      if (wr_en && (wr_addr != AW'(0)) && !busy_vec[wr_addr]) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule : rf_scoreboard

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through bypass and an attached
// pending-write scoreboard for in-order issue.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = RV_XLEN,
  parameter int unsigned NREG = RV_NREG,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_valid,
  input  logic            iss_wr,
  input  logic [AW-1:0]   iss_rd,
  output logic            stall,
  output logic [NREG-1:0] busy_vec,
  output logic            wb_err
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != AW'(0))) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Bypass is suppressed while reset is asserted so reads show stored contents.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != AW'(0)) begin
      rs1_data = (rst_n && wr_en && (wr_addr == rs1_addr)) ? wr_data : regs[rs1_addr];
    end
    if (rs2_addr != AW'(0)) begin
      rs2_data = (rst_n && wr_en && (wr_addr == rs2_addr)) ? wr_data : regs[rs2_addr];
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_wr    (iss_wr),
    .iss_rd    (iss_rd),
    .stall     (stall),
    .busy_vec  (busy_vec),
    .wb_err    (wb_err)
  );

endmodule : regfile_scoreboard

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of every register.
REQ-002 SHALL have parameter NREG, default 32: register count, power of two, at least 2.
REQ-003 SHALL have parameter AW, default $clog2(NREG): register address width.
REQ-004 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: rs1_addr, rs2_addr  in  AW  read addresses; rs1_used, rs2_used  in  1  operand actually consumed.
REQ-007 SHALL have ports: rs1_data, rs2_data  out  XLEN  read data.
REQ-008 SHALL have ports: wr_en  in  1; wr_addr  in  AW; wr_data  in  XLEN  writeback port.
REQ-009 SHALL have ports: iss_valid  in  1  instruction issuing; iss_wr  in  1  instruction writes rd; iss_rd  in  AW  destination.
REQ-010 SHALL have ports: stall  out  1  issue blocked; busy_vec  out  NREG  pending-write bit per register; wb_err  out  1  sticky writeback-to-idle-register error.

Function
REQ-011 SHALL read combinationally: rsN_data = reg[rsN_addr]; register 0 reads 0.
REQ-012 SHALL bypass writes: wr_en=1, wr_addr=rsN_addr≠0 gives rsN_data=wr_data in the same cycle.
REQ-013 SHALL write reg[wr_addr]<=wr_data on the rising edge when wr_en=1 and wr_addr≠0; writes to register 0 are discarded.
REQ-014 SHALL assert stall combinationally when iss_valid=1 and, for either operand N, rsN_used=1, busy_vec[rsN_addr]=1 and it is not being cleared this cycle (wr_en=1, wr_addr=rsN_addr).
REQ-015 SHALL also assert stall on WAW: iss_valid=1, iss_wr=1, iss_rd≠0, and busy_vec[iss_rd]=1 with no same-cycle clear.
REQ-016 SHALL set busy_vec[iss_rd] on the edge when iss_valid=1, iss_wr=1, iss_rd≠0, stall=0.
REQ-017 SHALL clear busy_vec[wr_addr] on the edge when wr_en=1.
REQ-018 SHALL resolve a same-cycle set and clear of one register as set.
REQ-019 SHALL hold busy_vec[0] at 0 permanently.
REQ-020 SHALL set wb_err on the edge when wr_en=1, wr_addr≠0 and busy_vec[wr_addr]=0; wb_err stays 1 until reset, and the data write still occurs.
REQ-021 SHALL drive stall low whenever iss_valid=0, regardless of operand state.

Reset
REQ-022 SHALL, on a rising edge with rst_n=0, clear all registers, busy_vec and wb_err, overriding any simultaneous write or issue.
REQ-023 SHALL let reads during reset return pre-edge contents; from the first edge with rst_n=0 onward, reads return 0.

Structure
REQ-024 SHALL take default XLEN and NREG from the shared core package (rv_pkg) as localparams.
REQ-025 SHALL place the scoreboard (busy_vec, stall, wb_err) in one sub-module, rf_scoreboard; the storage array and bypass live in the top.

Verification
REQ-026 SHALL test that after reset, reading any rs1/rs2 gives 0, busy_vec=0 and wb_err=0.
REQ-027 SHALL test that wr_en=1, wr_addr=5, wr_data=0xDEADBEEF with rs1_addr=5 in the same cycle gives rs1_data=0xDEADBEEF before the edge; a read of register 5 the next cycle gives the same value.
REQ-028 SHALL test that issuing rd=7 sets busy_vec[7]; a next issue with rs2_addr=7, rs2_used=1 gives stall=1; a writeback to 7 in that cycle gives stall=0 and busy_vec[7] stays 1 if the issue targets rd=7.
REQ-029 SHALL test that a write to register 0 of 0xFFFFFFFF leaves reads of register 0 at 0, busy_vec[0]=0 and no wb_err.
REQ-030 SHALL test that a writeback to register 9 while not busy sets wb_err=1 one cycle later, holds it, and that a reset clears it.
REQ-031 SHALL test that rst_n=0 mid-stream with busy_vec=0x0000_0F00 and a concurrent write and issue gives all zeros after the edge, with no write committed.
